sync_filter: RTL and testbench

SYNC_FILTER -- requirements
Module: sync_filter

---
 rtl/sync_pkg.sv | 14 +
 rtl/sync_nstage.sv | 33 +++
 rtl/sync_filter.sv | 83 ++++++++
 tb/tb_sync_filter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared limits and width helper for the synchronizer/debounce blocks.
package sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 8;
    localparam int FILT_LEN_MIN    = 1;
    localparam int FILT_LEN_MAX    = 65535;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_nstage.sv
// Multi-flop synchronizer chain, one chain per channel, synchronous reset.
module sync_nstage
    import sync_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sync_nstage: STAGES=%0d outside %0d..%0d",
               STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_filter.sv
// Synchronize and debounce WIDTH async inputs; optional rise/fall pulses
// are compiled in only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter
    import sync_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter int               STAGES   = 2,
    parameter int               FILT_LEN = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
        $error("sync_filter: FILT_LEN=%0d outside %0d..%0d",
               FILT_LEN, FILT_LEN_MIN, FILT_LEN_MAX);
    end

    localparam int            CW       = cnt_width(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [WIDTH-1:0] sync;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] load;

    sync_nstage #(
        .WIDTH   (WIDTH),
        .STAGES  (STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (sync)
    );

    // A channel commits when it has disagreed with out for FILT_LEN edges.
    always_comb begin
        load = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load[i] = (sync[i] != out[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == out[i] || load[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
                if (load[i]) out[i] <= sync[i];
            end
        end
    end

`ifdef SYNC_FILTER_EDGE_EN
    // Pulses share the edge at which out updates, so a reset-forced
    // change of out never produces one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= load & sync;
            fall <= load & ~sync;
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter at WIDTH=4, STAGES=3, FILT_LEN=4.
module tb_sync_filter;

`ifdef SYNC_FILTER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'h0;
    logic [3:0] out, rise, fall;

    int n_vec = 0;
    int n_err = 0;

    sync_filter #(
        .WIDTH    (4),
        .STAGES   (3),
        .FILT_LEN (4),
        .RST_VAL  (4'h0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (din),
        .out  (out),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int k,
                           input logic [3:0] e_out, input logic [3:0] e_rise,
                           input logic [3:0] e_fall);
        chk($sformatf("%s.out@%0d", tag, k), out, e_out);
        chk($sformatf("%s.rise@%0d", tag, k), rise, EDGE ? e_rise : 4'h0);
        chk($sformatf("%s.fall@%0d", tag, k), fall, EDGE ? e_fall : 4'h0);
    endtask

    // Drive a new stable level and expect out to switch at edge 7 (3 + 4).
    task automatic step_phase(input string tag, input logic [3:0] old_v,
                              input logic [3:0] new_v, input int n);
        din = new_v;
        for (int k = 1; k <= n; k++) begin
            tick();
            chk_all(tag, k, (k >= 7) ? new_v : old_v,
                    (k == 7) ? (new_v & ~old_v) : 4'h0,
                    (k == 7) ? (old_v & ~new_v) : 4'h0);
        end
    endtask

    initial begin
        // Reset with all inputs high: nothing leaks through.
        rst = 1'b1;
        din = 4'hF;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk_all("reset", k, 4'h0, 4'h0, 4'h0);
        end
        din = 4'h0;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_all("post_reset", k, 4'h0, 4'h0, 4'h0);
        end

        step_phase("step", 4'h0, 4'h1, 9);

        // 3-cycle excursion on channel 1: filtered out.
        din = 4'h3;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) din = 4'h1;
            tick();
            chk_all("glitch3", k, 4'h1, 4'h0, 4'h0);
        end

        // 4-cycle excursion: passes, rise at edge 7 and fall at edge 11.
        din = 4'h3;
        for (int k = 1; k <= 14; k++) begin
            if (k == 5) din = 4'h1;
            tick();
            chk_all("glitch4", k, (k >= 7 && k < 11) ? 4'h3 : 4'h1,
                    (k == 7) ? 4'h2 : 4'h0, (k == 11) ? 4'h2 : 4'h0);
        end

        step_phase("to8", 4'h1, 4'h8, 9);
        step_phase("simul", 4'h8, 4'h4, 9);

        // Reset from out=4: forced change produces no fall pulse.
        rst = 1'b1;
        din = 4'h0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk_all("rst_clear", k, 4'h0, 4'h0, 4'h0);
        end
        rst = 1'b0;

        // Step on channel 0 aborted by a reset at edge 5.
        din = 4'h1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_all("midcnt", k, 4'h0, 4'h0, 4'h0);
        end
        rst = 1'b1;
        tick();
        chk_all("midcnt", 5, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        step_phase("after_rst", 4'h0, 4'h1, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
